// File: rtl/mem_lsu_if.sv
// rtl/mem_lsu_if.sv - data bus bundle between mem_lsu and the data memory
interface mem_lsu_if;
   logic        dbus_req;
   logic        dbus_we;
   logic [31:0] dbus_addr;
   logic [31:0] dbus_wdata;
   logic [3:0]  dbus_sel;
   logic [31:0] dbus_rdata;
   logic        dbus_ack;

   modport master (
      output dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_sel,
      input  dbus_rdata, dbus_ack
   );

   modport slave (
      input  dbus_req, dbus_we, dbus_addr, dbus_wdata, dbus_sel,
      output dbus_rdata, dbus_ack
   );
endinterface

// File: rtl/mem_lsu.sv
// rtl/mem_lsu.sv - memory-access stage with req/ack data bus (optional MISALIGN_CHK_EN fault check)
module mem_lsu #(
   parameter int TIMEOUT = 255
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  ex_wd,
   input  logic        ex_wreg,
   input  logic [31:0] ex_wdata,
   input  logic        ex_mem_re,
   input  logic        ex_mem_we,
   input  logic [2:0]  ex_mem_size,
   input  logic [31:0] ex_mem_addr,
   input  logic [31:0] ex_mem_sdata,
   output logic [4:0]  mem_wd,
   output logic        mem_wreg,
   output logic [31:0] mem_wdata,
   output logic        stall_req,
   output logic        mem_excp,
   mem_lsu_if.master   dbus
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

   localparam logic [7:0] TIMEOUT_M1 = 8'(TIMEOUT - 1);

   state_t      state_q;
   logic        dbus_req_q;
   logic        dbus_we_q;
   logic [31:0] dbus_addr_q;
   logic [31:0] dbus_wdata_q;
   logic [3:0]  dbus_sel_q;
   logic [31:0] ld_q;
   logic        err_q;
   logic [7:0]  cnt_q;
   logic [2:0]  size_q;
   logic [1:0]  lo_q;

   logic        access;
   logic        fault;
   logic [31:0] bus_wdata_d;
   logic [3:0]  bus_sel_d;
   logic [31:0] ld_ext_d;

   assign access = ex_mem_re | ex_mem_we;

`ifdef MISALIGN_CHK_EN
   // Halves must be 2-byte aligned, words 4-byte aligned; a fault never reaches the bus.
   assign fault = access &
                  (((ex_mem_size[1:0] == 2'b01) & ex_mem_addr[0]) |
                   ((ex_mem_size[1:0] == 2'b10) & (|ex_mem_addr[1:0])));
`else
   assign fault = 1'b0;
`endif

   // Store lane replication and byte enables; loads read the full word.
   always_comb begin
      bus_wdata_d = ex_mem_sdata;
      bus_sel_d   = 4'b1111;
      if (ex_mem_we) begin
         case (ex_mem_size[1:0])
            2'b00: begin
               bus_wdata_d = {4{ex_mem_sdata[7:0]}};
               bus_sel_d   = 4'b0001 << ex_mem_addr[1:0];
            end
            2'b01: begin
               bus_wdata_d = {2{ex_mem_sdata[15:0]}};
               bus_sel_d   = 4'b0011 << {ex_mem_addr[1], 1'b0};
            end
            default: begin
               bus_wdata_d = ex_mem_sdata;
               bus_sel_d   = 4'b1111;
            end
         endcase
      end
   end

   // Lane extraction of the returned word using the offset latched at issue time.
   always_comb begin
      logic [31:0] shifted;
      logic [7:0]  byte_v;
      logic [15:0] half_v;
      shifted = dbus.dbus_rdata >> {lo_q, 3'b000};
      byte_v  = shifted[7:0];
      half_v  = lo_q[1] ? dbus.dbus_rdata[31:16] : dbus.dbus_rdata[15:0];
      case (size_q)
         3'b000:  ld_ext_d = {{24{byte_v[7]}}, byte_v};
         3'b001:  ld_ext_d = {{16{half_v[15]}}, half_v};
         3'b100:  ld_ext_d = {24'h0, byte_v};
         3'b101:  ld_ext_d = {16'h0, half_v};
         default: ld_ext_d = dbus.dbus_rdata;
      endcase
   end

   // Access FSM; bus outputs, load data and error flag are all registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         dbus_req_q   <= 1'b0;
         dbus_we_q    <= 1'b0;
         dbus_addr_q  <= 32'h0;
         dbus_wdata_q <= 32'h0;
         dbus_sel_q   <= 4'h0;
         ld_q         <= 32'h0;
         err_q        <= 1'b0;
         cnt_q        <= 8'h0;
         size_q       <= 3'h0;
         lo_q         <= 2'h0;
      end else begin
         case (state_q)
            IDLE: begin
               if (access && !fault) begin
                  dbus_req_q   <= 1'b1;
                  dbus_we_q    <= ex_mem_we;
                  dbus_addr_q  <= {ex_mem_addr[31:2], 2'b00};
                  dbus_wdata_q <= bus_wdata_d;
                  dbus_sel_q   <= bus_sel_d;
                  size_q       <= ex_mem_size;
                  lo_q         <= ex_mem_addr[1:0];
                  cnt_q        <= 8'h0;
                  err_q        <= 1'b0;
                  state_q      <= REQ;
               end
            end
            REQ: begin
               // An ack on the final allowed cycle still wins over the abort.
               if (dbus.dbus_ack) begin
                  if (!dbus_we_q) begin
                     ld_q <= ld_ext_d;
                  end
                  dbus_req_q <= 1'b0;
                  state_q    <= DONE;
               end else if (cnt_q == TIMEOUT_M1) begin
                  dbus_req_q <= 1'b0;
                  err_q      <= 1'b1;
                  state_q    <= DONE;
               end else begin
                  cnt_q <= cnt_q + 8'h1;
               end
            end
            DONE: begin
               err_q   <= 1'b0;
               cnt_q   <= 8'h0;
               state_q <= IDLE;
            end
            default: begin
               dbus_req_q <= 1'b0;
               state_q    <= IDLE;
            end
         endcase
      end
   end

   // Results towards mem_wb: pass-through when idle, load data or fault in DONE.
   always_comb begin
      mem_wd    = ex_wd;
      mem_wreg  = ex_wreg;
      mem_wdata = ex_wdata;
      stall_req = 1'b0;
      mem_excp  = 1'b0;
      if (rst) begin
         mem_wd    = 5'h0;
         mem_wreg  = 1'b0;
         mem_wdata = 32'h0;
      end else begin
         case (state_q)
            IDLE: begin
               if (fault) begin
                  mem_wreg = 1'b0;
                  mem_excp = 1'b1;
               end else if (access) begin
                  stall_req = 1'b1;
                  mem_wreg  = 1'b0;
               end
            end
            REQ: begin
               stall_req = 1'b1;
               mem_wreg  = 1'b0;
            end
            DONE: begin
               if (err_q) begin
                  mem_wreg = 1'b0;
                  mem_excp = 1'b1;
               end else if (dbus_we_q) begin
                  mem_wreg = 1'b0;
               end else begin
                  mem_wdata = ld_q;
               end
            end
            default: begin
               mem_wreg = 1'b0;
            end
         endcase
      end
   end

   assign dbus.dbus_req   = dbus_req_q;
   assign dbus.dbus_we    = dbus_we_q;
   assign dbus.dbus_addr  = dbus_addr_q;
   assign dbus.dbus_wdata = dbus_wdata_q;
   assign dbus.dbus_sel   = dbus_sel_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb/tb_mem_lsu.sv - scoreboard bench for mem_lsu
module tb_mem_lsu;
   localparam int TO = 4;

   logic        clk;
   logic        rst;
   logic [4:0]  ex_wd;
   logic        ex_wreg;
   logic [31:0] ex_wdata;
   logic        ex_mem_re;
   logic        ex_mem_we;
   logic [2:0]  ex_mem_size;
   logic [31:0] ex_mem_addr;
   logic [31:0] ex_mem_sdata;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        stall_req;
   logic        mem_excp;

   mem_lsu_if bus ();

   mem_lsu #(.TIMEOUT(TO)) dut (
      .clk          (clk),
      .rst          (rst),
      .ex_wd        (ex_wd),
      .ex_wreg      (ex_wreg),
      .ex_wdata     (ex_wdata),
      .ex_mem_re    (ex_mem_re),
      .ex_mem_we    (ex_mem_we),
      .ex_mem_size  (ex_mem_size),
      .ex_mem_addr  (ex_mem_addr),
      .ex_mem_sdata (ex_mem_sdata),
      .mem_wd       (mem_wd),
      .mem_wreg     (mem_wreg),
      .mem_wdata    (mem_wdata),
      .stall_req    (stall_req),
      .mem_excp     (mem_excp),
      .dbus         (bus.master)
   );

   typedef struct {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        excp;
      logic [31:0] baddr;
      logic [31:0] bwd;
      logic [3:0]  sel;
      logic        bwe;
      int          req_n;
      int          stall_n;
   } exp_t;

   exp_t sb[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_load(input logic [2:0] sz, input logic [1:0] a, input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      case (a)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = a[1] ? rd[31:16] : rd[15:0];
      case (sz)
         3'b000:  return {{24{b[7]}}, b};
         3'b001:  return {{16{h[15]}}, h};
         3'b100:  return {24'h0, b};
         3'b101:  return {16'h0, h};
         default: return rd;
      endcase
   endfunction

   task automatic m_store(input logic [2:0] sz, input logic [1:0] a, input logic [31:0] sd,
                          output logic [31:0] wd, output logic [3:0] sel);
      case (sz[1:0])
         2'b00: begin
            wd = {sd[7:0], sd[7:0], sd[7:0], sd[7:0]};
            case (a)
               2'd0:    sel = 4'b0001;
               2'd1:    sel = 4'b0010;
               2'd2:    sel = 4'b0100;
               default: sel = 4'b1000;
            endcase
         end
         2'b01: begin
            wd  = {sd[15:0], sd[15:0]};
            sel = a[1] ? 4'b1100 : 4'b0011;
         end
         default: begin
            wd  = sd;
            sel = 4'b1111;
         end
      endcase
   endtask

   task automatic do_access(input string tag, input logic re, input logic we, input logic [2:0] sz,
                            input logic [31:0] addr, input logic [31:0] sd, input logic [31:0] rd,
                            input int wait_cyc, input bit give_ack);
      exp_t        e;
      exp_t        g;
      logic        flt;
      int          req_n;
      int          stall_n;
      bit          seen;
      logic [31:0] got_addr;
      logic [31:0] got_wd;
      logic [3:0]  got_sel;
      logic        got_we;
      flt = 1'b0;
`ifdef MISALIGN_CHK_EN
      flt = ((sz[1:0] == 2'b01) && addr[0]) || ((sz[1:0] == 2'b10) && (addr[1:0] != 2'b00));
`endif
      e.wd    = 5'($urandom_range(1, 31));
      e.baddr = {addr[31:2], 2'b00};
      e.bwe   = we;
      if (we) begin
         m_store(sz, addr[1:0], sd, e.bwd, e.sel);
      end else begin
         e.bwd = 32'h0;
         e.sel = 4'b1111;
      end
      if (flt) begin
         e.req_n = 0;
         e.excp  = 1'b1;
      end else if (give_ack && (wait_cyc + 1 <= TO)) begin
         e.req_n = wait_cyc + 1;
         e.excp  = 1'b0;
      end else begin
         e.req_n = TO;
         e.excp  = 1'b1;
      end
      e.stall_n = flt ? 0 : e.req_n + 1;
      e.wreg    = !we && !e.excp;
      e.wdata   = m_load(sz, addr[1:0], rd);
      sb.push_back(e);

      @(negedge clk);
      ex_wd        = e.wd;
      ex_wreg      = 1'b1;
      ex_wdata     = 32'h5555_AAAA;
      ex_mem_re    = re;
      ex_mem_we    = we;
      ex_mem_size  = sz;
      ex_mem_addr  = addr;
      ex_mem_sdata = sd;
      #1;
      seen     = 1'b0;
      req_n    = 0;
      stall_n  = 0;
      got_addr = 32'h0;
      got_wd   = 32'h0;
      got_sel  = 4'h0;
      got_we   = 1'b0;
      for (int c = 0; c < 64; c++) begin
         if (bus.dbus_req) begin
            req_n++;
            if (!seen) begin
               got_addr = bus.dbus_addr;
               got_wd   = bus.dbus_wdata;
               got_sel  = bus.dbus_sel;
               got_we   = bus.dbus_we;
               seen     = 1'b1;
            end
            bus.dbus_ack   = give_ack && (req_n == wait_cyc + 1);
            bus.dbus_rdata = bus.dbus_ack ? rd : 32'h0;
         end else begin
            bus.dbus_ack = 1'b0;
         end
         if (!stall_req) break;
         stall_n++;
         @(negedge clk);
         #1;
      end

      g = sb.pop_front();
      chk({tag, "_stall_cycles"}, stall_n, g.stall_n);
      chk({tag, "_req_cycles"}, req_n, g.req_n);
      if (g.req_n > 0) begin
         chk({tag, "_dbus_addr"}, got_addr, g.baddr);
         chk({tag, "_dbus_sel"}, {28'h0, got_sel}, {28'h0, g.sel});
         chk({tag, "_dbus_we"}, got_we, g.bwe);
         if (g.bwe) chk({tag, "_dbus_wdata"}, got_wd, g.bwd);
      end
      chk({tag, "_excp"}, mem_excp, g.excp);
      chk({tag, "_wreg"}, mem_wreg, g.wreg);
      chk({tag, "_wd"}, {27'h0, mem_wd}, {27'h0, g.wd});
      if (g.wreg) chk({tag, "_wdata"}, mem_wdata, g.wdata);
      bus.dbus_ack = 1'b0;
      ex_mem_re    = 1'b0;
      ex_mem_we    = 1'b0;
   endtask

   initial begin
      logic [2:0] szs [5];
      szs = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
      rst            = 1'b1;
      ex_wd          = 5'd7;
      ex_wreg        = 1'b1;
      ex_wdata       = 32'h1111_2222;
      ex_mem_re      = 1'b0;
      ex_mem_we      = 1'b0;
      ex_mem_size    = 3'b000;
      ex_mem_addr    = 32'h0;
      ex_mem_sdata   = 32'h0;
      bus.dbus_ack   = 1'b0;
      bus.dbus_rdata = 32'h0;
      #12;
      chk("rst_dbus_req", bus.dbus_req, 1'b0);
      chk("rst_dbus_sel", {28'h0, bus.dbus_sel}, 32'h0);
      chk("rst_dbus_addr", bus.dbus_addr, 32'h0);
      chk("rst_mem_wreg", mem_wreg, 1'b0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_mem_wd", {27'h0, mem_wd}, 32'h0);
      chk("rst_stall", stall_req, 1'b0);
      @(negedge clk);
      rst = 1'b0;

      // ALU pass-through
      @(negedge clk);
      ex_wd    = 5'd5;
      ex_wdata = 32'hDEAD_BEEF;
      ex_wreg  = 1'b1;
      #1;
      chk("alu_wd", {27'h0, mem_wd}, 32'd5);
      chk("alu_wdata", mem_wdata, 32'hDEAD_BEEF);
      chk("alu_wreg", mem_wreg, 1'b1);
      chk("alu_stall", stall_req, 1'b0);
      chk("alu_excp", mem_excp, 1'b0);

      do_access("lb_ack0", 1'b1, 1'b0, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_0000, 0, 1'b1);
      do_access("sh_wait3", 1'b0, 1'b1, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3, 1'b1);
      do_access("lw_timeout", 1'b1, 1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'h0, 0, 1'b0);
      do_access("lw_misalign", 1'b1, 1'b0, 3'b010, 32'h0000_3001, 32'h0, 32'hCAFE_F00D, 1, 1'b1);
      do_access("lhu_hi", 1'b1, 1'b0, 3'b101, 32'h0000_4002, 32'h0, 32'h8765_4321, 2, 1'b1);
      do_access("lbu_b1", 1'b1, 1'b0, 3'b100, 32'h0000_4005, 32'h0, 32'h0000_9A00, 1, 1'b1);
      do_access("sb_b3", 1'b0, 1'b1, 3'b000, 32'h0000_5007, 32'h0000_00A5, 32'h0, 0, 1'b1);
      do_access("sw_both", 1'b1, 1'b1, 3'b010, 32'h0000_6000, 32'h0BAD_CAFE, 32'h0, 1, 1'b1);

      for (int i = 0; i < 8; i++) begin
         logic [2:0]  sz;
         logic [31:0] a;
         logic        st;
         st = 1'($urandom_range(0, 1));
         sz = st ? szs[$urandom_range(0, 2)] : szs[$urandom_range(0, 4)];
         a  = $urandom;
         if (sz[1:0] == 2'b01) a[0] = 1'b0;
         if (sz[1:0] == 2'b10) a[1:0] = 2'b00;
         do_access($sformatf("rnd%0d", i), !st, st, sz, a, $urandom, $urandom,
                   int'($urandom_range(0, 2)), 1'b1);
      end

      // Reset while a load is waiting in REQ; a late ack must have no effect.
      @(negedge clk);
      ex_wd       = 5'd9;
      ex_wreg     = 1'b1;
      ex_wdata    = 32'h7777_8888;
      ex_mem_re   = 1'b1;
      ex_mem_size = 3'b010;
      ex_mem_addr = 32'h0000_0040;
      @(negedge clk);
      chk("rstreq_pre_req", bus.dbus_req, 1'b1);
      #1;
      rst = 1'b1;
      #1;
      chk("rstreq_req_async", bus.dbus_req, 1'b0);
      chk("rstreq_stall", stall_req, 1'b0);
      chk("rstreq_wreg", mem_wreg, 1'b0);
      chk("rstreq_wdata", mem_wdata, 32'h0);
      @(negedge clk);
      ex_mem_re      = 1'b0;
      ex_wreg        = 1'b0;
      rst            = 1'b0;
      bus.dbus_ack   = 1'b1;
      bus.dbus_rdata = 32'h1234_5678;
      @(negedge clk);
      chk("late_ack_req", bus.dbus_req, 1'b0);
      chk("late_ack_stall", stall_req, 1'b0);
      chk("late_ack_wreg", mem_wreg, 1'b0);
      chk("late_ack_wdata", mem_wdata, 32'h7777_8888);
      bus.dbus_ack = 1'b0;

      do_access("post_rst_lh", 1'b1, 1'b0, 3'b001, 32'h0000_0042, 32'h0, 32'h8001_0002, 0, 1'b1);

      @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
